hazard_ctrl_param: RTL and testbench
====================================

// Module: hazard_ctrl_param
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order CPU pipeline; successor to the fixed 3-writer flow control.
//  Tracks destination addresses of NSTAGE post-decode stages in an internal shadow pipeline and selects forwarding data for ID.
//  Issues per-stage 2-bit cond codes to IF, ID and each post-decode stage.
//  Owns the multi-cycle mult/div busy FSM with timeout, plus a stall-cycle counter.
// PARAMETERS
//  NSTAGE     3   post-decode stages that can write (stage 0 = EX, NSTAGE-1 = WB)
//  AW         7   register address width (GPR + HI/LO/CP0 encoding); address 0 never hazards
//  DW         32  data width
//  MD_TMO     64  max mult/div BUSY cycles before forced exit
//  CNT_W      16  stall counter width
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-high reset
//  cpu_stall    in   1           external freeze of the whole pipeline
//  id_raddr1    in   AW          ID source address A (ALUa)
//  id_raddr2    in   AW          ID source address B (ALUb/Rt)
//  id_waddr     in   AW          ID destination address
//  id_wen       in   1           ID instruction writes id_waddr
//  id_md        in   1           ID instruction is mult/div
//  md_done      in   1           mult/div unit finished (pulse)
//  fwd_data     in   NSTAGE*DW   result per stage, slice k = stage k
//  fwd_ready    in   NSTAGE      slice k valid (0 for a load in EX)
//  fwd_a        out  DW          forwarded value for source A
//  fwd_a_hit    out  1           use fwd_a instead of regfile
//  fwd_b        out  DW          forwarded value for source B
//  fwd_b_hit    out  1           use fwd_b instead of regfile
//  cond         out  2*(NSTAGE+2) [1:0]=IF, [3:2]=ID, then stage 0..NSTAGE-1
//  md_busy      out  1           mult/div FSM in BUSY
//  md_timeout   out  1           sticky: BUSY exited by timeout
//  stall_cnt    out  CNT_W       cycles with ID not advancing (saturating)
// BEHAVIOUR
//  cond codes: 2'b00 RUN (latch new input), 2'b01 HOLD (keep register), 2'b10 BUBBLE (load NOP/invalid). 2'b11 never driven.
//  Reset: shadow pipeline empty (all sb_wen=0), FSM IDLE, md_timeout=0, stall_cnt=0.
//   Resulting outputs: cond all RUN, fwd_*_hit=0, fwd_a=fwd_b=0.
//  fwd_*, cond: combinational from state and inputs, 0 latency. All state updates on clk.
//  Forwarding, per source s:
//   Match k when sb_wen[k] and sb_addr[k]==raddr_s and raddr_s!=0. The lowest k (youngest) wins.
//   Match with fwd_ready[k]=1: hit=1, value = fwd_data slice k.
//   Match with fwd_ready[k]=0: load-use hazard (LU).
//   No match: hit=0, value=0.
//  Priority (highest first):
//   1. cpu_stall: all cond HOLD; shadow, FSM and counter frozen.
//   2. md_busy: IF/ID/stage0 HOLD, stage1 BUBBLE, stages>=2 RUN.
//      Shadow: sb[0] held, sb[1] emptied, sb[k>=2] shift.
//   3. LU: IF/ID HOLD, stage0 BUBBLE, others RUN. Shadow: sb[0] emptied, rest shift.
//   4. Otherwise: all RUN. sb[0] <= {id_waddr, id_wen}, sb[k] <= sb[k-1].
//  stall_cnt += 1 on every cycle in cases 2 or 3 (not cpu_stall). Saturates at all-ones.
//  Mult/div FSM IDLE->BUSY:
//   Taken when ID advances (case 4) with id_md=1; cnt cleared.
//  Mult/div FSM BUSY->IDLE:
//   On md_done, or when cnt==MD_TMO-1; the timeout path sets md_timeout.
//   Exit cycle still reports md_busy=1; pipeline resumes the next cycle.
//  md_done while IDLE is ignored. md_done and timeout in the same cycle: md_done wins, md_timeout not set.
//  NSTAGE=1: stage1 terms are absent; md_busy leaves stage0 HOLD and nothing drains.
//  Reset mid-BUSY or mid-LU: immediate return to reset state. Any in-flight op is dropped.
// TESTING
//  1. Reset asserted async mid-cycle -> cond==0, hits 0, stall_cnt 0 before next edge.
//  2. Back-to-back ALU: issue $5 write, then read $5 -> fwd_a_hit=1, fwd_a=fwd_data[stage0] (0x1234), no stall.
//  3. Load-use: $6 write with fwd_ready[0]=0, next reads $6 ->
//     one cycle ID HOLD + stage0 BUBBLE, then hit from stage1; stall_cnt=1.
//  4. Priority: $7 in stage0 (0xAAAA) and stage2 (0xBBBB) -> fwd_b=0xAAAA.
//     Reading $0 with sb_addr=0 -> hit=0.
//  5. Mult/div: md_done after 5 BUSY cycles -> 5 cycles ID HOLD, stage1 BUBBLE; IDLE after.
//     Without md_done: exits at MD_TMO, md_timeout=1.
//  6. cpu_stall during BUSY for 3 cycles -> all HOLD, FSM cnt and stall_cnt unchanged; BUSY resumes after.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// Hazard/forwarding controller: shadow pipeline of NSTAGE destination tags, ID forwarding mux,
// per-stage RUN/HOLD/BUBBLE codes, mult/div busy FSM with timeout and a saturating stall counter.
module hazard_ctrl_param #(
  parameter int NSTAGE = 3,
  parameter int AW     = 7,
  parameter int DW     = 32,
  parameter int MD_TMO = 64,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_stall,
  input  logic [AW-1:0]             id_raddr1,
  input  logic [AW-1:0]             id_raddr2,
  input  logic [AW-1:0]             id_waddr,
  input  logic                      id_wen,
  input  logic                      id_md,
  input  logic                      md_done,
  input  logic [NSTAGE*DW-1:0]      fwd_data,
  input  logic [NSTAGE-1:0]         fwd_ready,
  output logic [DW-1:0]             fwd_a,
  output logic                      fwd_a_hit,
  output logic [DW-1:0]             fwd_b,
  output logic                      fwd_b_hit,
  output logic [2*(NSTAGE+2)-1:0]   cond,
  output logic                      md_busy,
  output logic                      md_timeout,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int MCW = (MD_TMO > 1) ? $clog2(MD_TMO) : 1;
  localparam logic [1:0] C_RUN = 2'b00, C_HOLD = 2'b01, C_BUB = 2'b10;

  typedef enum logic [1:0] {M_STALL, M_MD, M_LU, M_RUN} mode_e;
  typedef enum logic {S_IDLE, S_BUSY} md_state_e;

  logic [NSTAGE-1:0]         sb_wen_q, sb_wen_d;
  logic [NSTAGE-1:0][AW-1:0] sb_addr_q, sb_addr_d;
  md_state_e                 md_state_q;
  logic [MCW-1:0]            md_cnt_q;
  logic                      md_timeout_q;
  logic [CNT_W-1:0]          stall_cnt_q;
  logic                      a_lu, b_lu;
  mode_e                     mode;

  // Iterate oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    fwd_a = '0; fwd_a_hit = 1'b0; a_lu = 1'b0;
    fwd_b = '0; fwd_b_hit = 1'b0; b_lu = 1'b0;
    for (int k = NSTAGE-1; k >= 0; k--) begin
      if (sb_wen_q[k] && sb_addr_q[k] == id_raddr1 && id_raddr1 != '0) begin
        fwd_a_hit = fwd_ready[k];
        a_lu      = !fwd_ready[k];
        fwd_a     = fwd_ready[k] ? fwd_data[k*DW +: DW] : '0;
      end
      if (sb_wen_q[k] && sb_addr_q[k] == id_raddr2 && id_raddr2 != '0) begin
        fwd_b_hit = fwd_ready[k];
        b_lu      = !fwd_ready[k];
        fwd_b     = fwd_ready[k] ? fwd_data[k*DW +: DW] : '0;
      end
    end
  end

  assign md_busy = (md_state_q == S_BUSY);

  always_comb begin
    if (cpu_stall)         mode = M_STALL;
    else if (md_busy)      mode = M_MD;
    else if (a_lu || b_lu) mode = M_LU;
    else                   mode = M_RUN;
  end

  always_comb begin
    cond = '0;
    case (mode)
      M_STALL: for (int k = 0; k < NSTAGE+2; k++) cond[2*k +: 2] = C_HOLD;
      M_MD: begin
        cond[1:0] = C_HOLD;
        cond[3:2] = C_HOLD;
        for (int k = 0; k < NSTAGE; k++) begin
          if (k == 0)      cond[2*k+4 +: 2] = C_HOLD;
          else if (k == 1) cond[2*k+4 +: 2] = C_BUB;
          else             cond[2*k+4 +: 2] = C_RUN;
        end
      end
      M_LU: begin
        cond[1:0] = C_HOLD;
        cond[3:2] = C_HOLD;
        cond[5:4] = C_BUB;
      end
      default: cond = '0;
    endcase
  end

  // Shadow tags follow the same hold/bubble/shift pattern as the real pipeline registers.
  always_comb begin
    sb_wen_d  = sb_wen_q;
    sb_addr_d = sb_addr_q;
    for (int k = 0; k < NSTAGE; k++) begin
      case (mode)
        M_MD: begin
          if (k == 1)     sb_wen_d[k] = 1'b0;
          else if (k > 1) begin
            sb_wen_d[k]  = sb_wen_q[k-1];
            sb_addr_d[k] = sb_addr_q[k-1];
          end
        end
        M_LU: begin
          if (k == 0) sb_wen_d[k] = 1'b0;
          else begin
            sb_wen_d[k]  = sb_wen_q[k-1];
            sb_addr_d[k] = sb_addr_q[k-1];
          end
        end
        M_RUN: begin
          if (k == 0) begin
            sb_wen_d[k]  = id_wen;
            sb_addr_d[k] = id_waddr;
          end else begin
            sb_wen_d[k]  = sb_wen_q[k-1];
            sb_addr_d[k] = sb_addr_q[k-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_wen_q    <= '0;
      sb_addr_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_wen_q  <= sb_wen_d;
      sb_addr_q <= sb_addr_d;
      if ((mode == M_MD || mode == M_LU) && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // md_done takes precedence over the timeout when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state_q   <= S_IDLE;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
    end else if (!cpu_stall) begin
      case (md_state_q)
        S_IDLE: if (mode == M_RUN && id_md) begin
          md_state_q <= S_BUSY;
          md_cnt_q   <= '0;
        end
        S_BUSY: begin
          if (md_done) begin
            md_state_q <= S_IDLE;
          end else if (md_cnt_q == MCW'(MD_TMO-1)) begin
            md_state_q   <= S_IDLE;
            md_timeout_q <= 1'b1;
          end else begin
            md_cnt_q <= md_cnt_q + 1'b1;
          end
        end
        default: md_state_q <= S_IDLE;
      endcase
    end
  end

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed-vector bench for hazard_ctrl_param with default parameters (NSTAGE=3, MD_TMO=64).
module tb_hazard_ctrl_param;

  localparam int NSTAGE = 3, AW = 7, DW = 32, MD_TMO = 64, CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cpu_stall;
  logic [AW-1:0]           id_raddr1, id_raddr2, id_waddr;
  logic                    id_wen, id_md, md_done;
  logic [NSTAGE*DW-1:0]    fwd_data;
  logic [NSTAGE-1:0]       fwd_ready;
  logic [DW-1:0]           fwd_a, fwd_b;
  logic                    fwd_a_hit, fwd_b_hit;
  logic [2*(NSTAGE+2)-1:0] cond;
  logic                    md_busy, md_timeout;
  logic [CNT_W-1:0]        stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [9:0] C_ALLRUN = 10'h000;
  localparam logic [9:0] C_LU     = 10'h025;
  localparam logic [9:0] C_MD     = 10'h095;
  localparam logic [9:0] C_STALL  = 10'h155;

  hazard_ctrl_param #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW), .MD_TMO(MD_TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cpu_stall(cpu_stall),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_waddr(id_waddr),
    .id_wen(id_wen), .id_md(id_md), .md_done(md_done),
    .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .fwd_a(fwd_a), .fwd_a_hit(fwd_a_hit), .fwd_b(fwd_b), .fwd_b_hit(fwd_b_hit),
    .cond(cond), .md_busy(md_busy), .md_timeout(md_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [AW-1:0] wa, input logic wen, input logic md,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    id_waddr = wa; id_wen = wen; id_md = md; id_raddr1 = r1; id_raddr2 = r2;
  endtask

  task automatic flush();
    set_id('0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < NSTAGE; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; cpu_stall = 1'b0; md_done = 1'b0;
    set_id('0, 1'b0, 1'b0, '0, '0);
    fwd_data = '0; fwd_ready = '1;
    #3;
    chk("rst_cond",  cond, C_ALLRUN);
    chk("rst_hit_a", fwd_a_hit, 0);
    chk("rst_a",     fwd_a, 0);
    chk("rst_busy",  md_busy, 0);
    chk("rst_stall", stall_cnt, 0);
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back ALU forwarding
    set_id(7'd5, 1'b1, 1'b0, '0, '0);
    tick();
    set_id('0, 1'b0, 1'b0, 7'd5, '0);
    fwd_data[0*DW +: DW] = 32'h1234;
    #2;
    chk("alu_hit",   fwd_a_hit, 1);
    chk("alu_val",   fwd_a, 32'h1234);
    chk("alu_cond",  cond, C_ALLRUN);
    chk("alu_bhit",  fwd_b_hit, 0);
    tick();
    fwd_data[1*DW +: DW] = 32'h5555;
    #2;
    chk("alu_st1",   fwd_a, 32'h5555);
    flush();

    // Load-use: one stall cycle then forward from stage 1
    set_id(7'd6, 1'b1, 1'b0, '0, '0);
    tick();
    set_id('0, 1'b0, 1'b0, 7'd6, '0);
    fwd_ready = 3'b110;
    #2;
    chk("lu_cond",   cond, C_LU);
    chk("lu_hit",    fwd_a_hit, 0);
    tick();
    fwd_ready = '1;
    fwd_data[1*DW +: DW] = 32'hCAFE;
    #2;
    chk("lu_cond2",  cond, C_ALLRUN);
    chk("lu_hit2",   fwd_a_hit, 1);
    chk("lu_val2",   fwd_a, 32'hCAFE);
    chk("lu_scnt",   stall_cnt, 1);
    flush();

    // Youngest stage wins; address 0 never hits
    set_id(7'd7, 1'b1, 1'b0, '0, '0); tick();
    set_id(7'd0, 1'b0, 1'b0, '0, '0); tick();
    set_id(7'd7, 1'b1, 1'b0, '0, '0); tick();
    fwd_data[0*DW +: DW] = 32'hAAAA;
    fwd_data[2*DW +: DW] = 32'hBBBB;
    set_id(7'd0, 1'b1, 1'b0, '0, 7'd7);
    #2;
    chk("pri_bhit",  fwd_b_hit, 1);
    chk("pri_bval",  fwd_b, 32'hAAAA);
    tick();
    fwd_data[1*DW +: DW] = 32'h7777;
    set_id('0, 1'b0, 1'b0, '0, 7'd7);
    #2;
    chk("zero_hit",  fwd_a_hit, 0);
    chk("zero_val",  fwd_a, 0);
    chk("pri_st1",   fwd_b, 32'h7777);
    flush();

    // Mult/div finished by md_done in the 5th BUSY cycle
    set_id('0, 1'b0, 1'b1, '0, '0);
    #2;
    chk("md_idle",   md_busy, 0);
    tick();
    id_md = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      md_done = (i == 5);
      #2;
      chk($sformatf("md_busy%0d", i), md_busy, 1);
      chk($sformatf("md_cond%0d", i), cond, C_MD);
      tick();
    end
    md_done = 1'b0;
    #2;
    chk("md_after",  md_busy, 0);
    chk("md_cond_r", cond, C_ALLRUN);
    chk("md_scnt",   stall_cnt, 6);
    chk("md_tmo0",   md_timeout, 0);

    // cpu_stall freezes BUSY, then timeout exit
    id_md = 1'b1;
    tick();
    id_md = 1'b0;
    tick(); tick();
    cpu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("stl_cond%0d", i), cond, C_STALL);
      tick();
    end
    cpu_stall = 1'b0;
    #2;
    chk("stl_scnt",  stall_cnt, 8);
    chk("stl_busy",  md_busy, 1);
    n = 0;
    while (md_busy && n < 200) begin
      n++;
      tick();
    end
    #1;
    chk("tmo_cycles", n, 62);
    chk("tmo_flag",  md_timeout, 1);
    chk("tmo_scnt",  stall_cnt, 70);
    chk("tmo_busy",  md_busy, 0);

    // Async reset in the middle of a BUSY cycle
    set_id(7'd5, 1'b1, 1'b1, '0, '0);
    tick();
    set_id('0, 1'b0, 1'b0, 7'd5, '0);
    #2;
    chk("ar_pre_hit",  fwd_a_hit, 1);
    chk("ar_pre_busy", md_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_cond",   cond, C_ALLRUN);
    chk("ar_hit",    fwd_a_hit, 0);
    chk("ar_aval",   fwd_a, 0);
    chk("ar_scnt",   stall_cnt, 0);
    chk("ar_tmo",    md_timeout, 0);
    chk("ar_busy",   md_busy, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
